// File: rtl/quad_pwm_gen.sv
// Four-channel PWM generator with shadowed period/duty words that only take
// effect at period boundaries, plus an emergency stop that overrides everything.

module quad_pwm_lane #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);
  logic [CNT_W-1:0] duty_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh <= '0;
      pwm     <= 1'b0;
    end else begin
      if (load) duty_sh <= duty;
      // duty_sh >= period keeps cnt < duty_sh true across the wrap: no low glitch
      pwm <= en && (cnt < duty_sh);
    end
  end
endmodule

module quad_pwm_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [CNT_W-1:0] duty_1_export,
  input  logic [CNT_W-1:0] duty_2_export,
  input  logic [CNT_W-1:0] duty_3_export,
  input  logic [CNT_W-1:0] duty_4_export,
  input  logic [CNT_W-1:0] period_export,
  input  logic [31:0]      stop_export,
  output logic [3:0]       pwm_out,
  output logic             cycle_start,
  output logic             running
);
  localparam int NUM_LANES = 4;

  typedef enum logic {STOPPED = 1'b0, RUN = 1'b1} state_t;

  state_t                            state, state_nxt;
  logic [CNT_W-1:0]                  cnt, cnt_nxt, per_sh;
  logic                              load, stop, per_nz, en;
  logic [NUM_LANES-1:0][CNT_W-1:0]   duty_in;
  logic                              unused_stop_bits;

  assign stop             = stop_export[0];
  assign unused_stop_bits = &{1'b0, stop_export[31:1]};
  assign duty_in          = {duty_4_export, duty_3_export, duty_2_export, duty_1_export};
  assign per_nz           = (per_sh != '0);
  assign en               = (state == RUN) && !stop && per_nz;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= STOPPED;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STOPPED: if (!stop) state_nxt = RUN;
      RUN:     if (stop)  state_nxt = STOPPED;
      default:            state_nxt = STOPPED;
    endcase
  end

  // Stop wins over everything; a zero period parks the counter and keeps reloading.
  always_comb begin
    load    = 1'b0;
    cnt_nxt = cnt;
    if (state == STOPPED) begin
      load    = 1'b1;
      cnt_nxt = '0;
    end else if (stop) begin
      cnt_nxt = '0;
    end else if (!per_nz || (cnt >= per_sh - CNT_W'(1))) begin
      load    = 1'b1;
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt         <= '0;
      per_sh      <= '0;
      cycle_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      if (load) per_sh <= period_export;
      cycle_start <= (state == RUN) && (cnt == '0) && per_nz;
      running     <= (state == RUN);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    quad_pwm_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .load  (load),
      .en    (en),
      .duty  (duty_in[i]),
      .cnt   (cnt),
      .pwm   (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_quad_pwm_gen.sv
// Bench for quad_pwm_gen: directed table, corner-case sequences and random
// stimulus, all checked every cycle against a period/phase reference model.

module tb_quad_pwm_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] duty1, duty2, duty3, duty4, period, stop;
  logic [3:0]  pwm;
  logic        cs, run;

  int tests = 0;
  int fails = 0;

  quad_pwm_gen #(.CNT_W(32)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .duty_1_export (duty1),
    .duty_2_export (duty2),
    .duty_3_export (duty3),
    .duty_4_export (duty4),
    .period_export (period),
    .stop_export   (stop),
    .pwm_out       (pwm),
    .cycle_start   (cs),
    .running       (run)
  );

  always #5 clk = ~clk;

  // Reference: running flag, phase within the active period, latched period/duties.
  bit     m_run;
  longint m_pos, m_per;
  longint m_duty[4];
  bit [3:0] e_pwm;
  bit       e_cs, e_run;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_pos = 0; m_per = 0;
    for (int n = 0; n < 4; n++) m_duty[n] = 0;
    e_pwm = '0; e_cs = 0; e_run = 0;
  endfunction

  function automatic void model_step();
    bit s;
    bit take;
    s = stop[0];
    for (int n = 0; n < 4; n++)
      e_pwm[n] = m_run && !s && (m_per != 0) && (m_pos < m_duty[n]);
    e_cs  = m_run && (m_pos == 0) && (m_per != 0);
    e_run = m_run;
    take  = !m_run;
    if (s) begin
      m_run = 0; m_pos = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0;
    end else if (m_per == 0 || m_pos + 1 >= m_per) begin
      m_pos = 0; take = 1;
    end else begin
      m_pos++;
    end
    if (take) begin
      m_per = longint'(period);
      m_duty[0] = longint'(duty1); m_duty[1] = longint'(duty2);
      m_duty[2] = longint'(duty3); m_duty[3] = longint'(duty4);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    chk("model_pwm", 64'(pwm), 64'(e_pwm));
    chk("model_cs",  64'(cs),  64'(e_cs));
    chk("model_run", 64'(run), 64'(e_run));
  endtask

  task automatic wait_cs();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cs === 1'b1) return;
    end
    chk("cs_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_pos(input longint p);
    for (int i = 0; i < 100; i++) begin
      if (m_pos == p && m_run) return;
      tick();
    end
    chk("pos_timeout", 64'd0, 64'd1);
  endtask

  // counts pwm[0] highs over the current sample plus n-1 further cycles
  task automatic count_hi(input int n, output int hi);
    hi = int'(pwm[0] === 1'b1);
    for (int i = 1; i < n; i++) begin
      tick();
      if (pwm[0] === 1'b1) hi++;
    end
  endtask

  typedef struct {
    logic [31:0] stop_in;
    logic [31:0] duty1_in;
    logic [3:0]  pwm_exp;
    logic        cs_exp;
    logic        run_exp;
  } vec_t;

  vec_t tbl[25];

  initial begin
    int hi, gap, bad, n;
    model_reset();
    duty1 = 3; duty2 = 0; duty3 = 0; duty4 = 0; period = 10; stop = 0;

    for (int k = 0; k < 25; k++) begin
      tbl[k].stop_in  = 32'd0;
      tbl[k].duty1_in = 32'd3;
      tbl[k].run_exp  = (k >= 1);
      tbl[k].cs_exp   = (k >= 1) && ((k - 1) % 10 == 0);
      tbl[k].pwm_exp  = {3'b000, (k >= 1) && ((k - 1) % 10 < 3)};
    end

    // 1: reset held, then 3-high/7-low with cycle_start on each rising edge
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm", 64'(pwm), 64'd0);
    chk("rst_cs",  64'(cs),  64'd0);
    chk("rst_run", 64'(run), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      stop = tbl[k].stop_in; duty1 = tbl[k].duty1_in;
      tick();
      chk("tbl_pwm", 64'(pwm), 64'(tbl[k].pwm_exp));
      chk("tbl_cs",  64'(cs),  64'(tbl[k].cs_exp));
      chk("tbl_run", 64'(run), 64'(tbl[k].run_exp));
    end

    // 2: mid-period duty and period changes wait for the boundary
    wait_pos(4);
    duty1 = 6;
    wait_cs();
    count_hi(10, hi);
    chk("duty_next_period", 64'(hi), 64'd6);
    wait_pos(4);
    period = 20;
    wait_cs();
    gap = 0;
    do begin tick(); gap++; end while (cs !== 1'b1 && gap < 60);
    chk("period_20_gap", 64'(gap), 64'd20);

    // 3: duty 0 stays low, duty >= period stays high through wraps
    period = 10; duty1 = 3; duty2 = 0; duty3 = 10; duty4 = 32'hFFFF_FFFF;
    wait_cs();
    bad = 0;
    for (int i = 0; i < 35; i++) begin
      if (pwm[1] !== 1'b0 || pwm[2] !== 1'b1 || pwm[3] !== 1'b1) bad++;
      tick();
    end
    chk("const_levels", 64'(bad), 64'd0);
    duty4 = 15;

    // 4: stop while ch1 high, then restart with a full first pulse
    wait_cs();
    stop = 32'd1;
    tick();
    chk("stop_pwm", 64'(pwm), 64'd0);
    tick();
    chk("stop_run", 64'(run), 64'd0);
    repeat (3) tick();
    stop = 32'd0;
    tick();
    tick();
    chk("restart_cs", 64'(cs), 64'd1);
    count_hi(10, hi);
    chk("restart_pulse", 64'(hi), 64'd3);
    stop = 32'h2;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (run !== 1'b1) bad++;
    end
    chk("stop_upper_bits", 64'(bad), 64'd0);
    stop = 32'd0;

    // 5: zero period silences everything; a new period resumes quickly
    period = 0; duty1 = 3; duty2 = 5; duty3 = 7; duty4 = 9;
    repeat (25) tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cs !== 1'b0 || pwm !== 4'b0000) bad++;
    end
    chk("period0_quiet", 64'(bad), 64'd0);
    period = 4;
    n = 0;
    do begin tick(); n++; end while (pwm === 4'b0000 && n < 10);
    chk("period4_resume", 64'(n), 64'd2);

    // 6: async reset mid-pulse
    wait_cs();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pwm", 64'(pwm), 64'd0);
    chk("arst_run", 64'(run), 64'd0);
    chk("arst_cs",  64'(cs),  64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("arst_restart_cs", 64'(cs), 64'd1);
    chk("arst_restart_pwm", 64'(pwm), 64'b1111);

    // random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) stop[0] = ~stop[0];
      stop[31:1] = 31'($urandom);
      if ($urandom_range(0, 11) == 0) period = $urandom_range(0, 12);
      if ($urandom_range(0, 7) == 0) duty1 = $urandom_range(0, 14);
      if ($urandom_range(0, 7) == 0) duty2 = $urandom_range(0, 14);
      if ($urandom_range(0, 7) == 0) duty3 = $urandom_range(0, 14);
      if ($urandom_range(0, 7) == 0)
        duty4 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 14));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/quad_pwm_gen.md
Name: quad_pwm_gen

Overview:
- Four-channel PWM generator for the ESC/motor outputs.
- Consumes the duty_1..4, period and stop words that the Nios soft-processor system exports.
- Sits directly downstream of the processor system and drives the four motor pins.
- Duty and period values are shadowed and take effect only at period boundaries, so software writes never produce runt or glitched pulses.

Parameters:
- CNT_W, 32, width of the period counter, duty words and period word (all compares unsigned).

Ports:
- clk_clk  in  1  system clock; the same clock as the processor system.
- reset_reset_n  in  1  asynchronous active-low reset.
- duty_1_export  in  CNT_W  channel 1 high time, in clk_clk cycles.
- duty_2_export  in  CNT_W  channel 2 high time.
- duty_3_export  in  CNT_W  channel 3 high time.
- duty_4_export  in  CNT_W  channel 4 high time.
- period_export  in  CNT_W  PWM period, in clk_clk cycles.
- stop_export  in  32  bit 0 = emergency stop; bits 31:1 are ignored.
- pwm_out  out  4  PWM outputs; bit n-1 = channel n.
- cycle_start  out  1  one-cycle pulse at the start of each running period.
- running  out  1  high while in the RUN state.

Behaviour:
- Reset (async assert, sync release):
  - state=STOPPED, cnt=0, all shadows=0.
  - pwm_out=4'b0000, cycle_start=0, running=0.
- Internal registers: cnt, per_sh, duty_sh[1..4], state ∈ {STOPPED, RUN}.
- Shadow load ("load"): per_sh<=period_export and duty_sh[n]<=duty_n_export, all in one cycle.
- Load occurs:
  - every cycle while STOPPED;
  - in RUN when cnt >= per_sh-1 (terminal count), with cnt<=0 in the same cycle;
  - in RUN every cycle while per_sh==0.
- Otherwise, in RUN, cnt<=cnt+1.
- Input changes mid-period are ignored until the next terminal count.
- Transitions:
  - STOPPED→RUN when stop_export[0]==0; cnt<=0 in that same cycle.
  - RUN→STOPPED when stop_export[0]==1, checked every cycle with priority over everything else; cnt<=0.
- Output register:
  - pwm_out[n-1] <= (state==RUN) && !stop_export[0] && (per_sh!=0) && (cnt < duty_sh[n]).
  - Latency: one cycle from cnt to pin.
  - Stop forces all outputs low on the first clock edge at which stop is sampled high.
  - Stop asserted mid-period aborts the period with no completion of the current pulse.
- Boundary cases:
  - duty_sh==0 → output constantly low.
  - duty_sh >= per_sh → output constantly high, with no low glitch at the wrap.
  - per_sh==0 → all outputs low and cnt held at 0; a nonzero period is picked up at the next load.
  - per_sh==1 → cnt stays 0; output high iff duty_sh >= 1.
- cycle_start is registered: it pulses one cycle after each cycle in which state==RUN and cnt==0 and per_sh!=0, i.e. aligned with the first pwm cycle of the period.
- running is registered as (state==RUN).
- Async reset mid-operation drops all outputs to 0 immediately. After release, the block waits in STOPPED until stop_export[0]==0.
- The block has no handshake: inputs are level registers from the processor system.
- Cross-check: 4 channels × 32-bit comparators plus shared counter, roughly 150–200 lines of RTL.

Test Plan:
1. Reset held with inputs period=10, duty_1=3, stop=0; release → pwm_out=0 during reset, then channel 1 produces a repeating 3-high/7-low pattern. cycle_start pulses every 10 cycles, aligned with each rising edge of pwm_out[0]; running=1.
2. duty_1 changed 3→6 at cnt=4 → current period still 3 high; next period 6 high. Repeat with period 10→20 mid-period → new period starts only after the current 10-cycle period completes.
3. duty_2=0, duty_3=10, duty_4=15 with period=10 → ch2 always 0; ch3 and ch4 continuously 1 across ≥3 wraps, never low.
4. stop_export=1 at cnt=1 while channel 1 is high → all pwm_out=0 from the next edge and running=0. stop_export=0 → counting restarts at cnt=0 with a full 3-cycle first pulse. stop_export=32'h2 has no effect.
5. period=0 with duties nonzero → pwm_out=0 and no cycle_start pulses. period set to 4 → PWM resumes within 2 cycles.
6. Async reset pulse asserted mid-pulse (not aligned to clk_clk) → pwm_out=0 immediately. After release, normal operation from cnt=0.
